// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM bus responder.
package sram_pkg;

    localparam int SRAM_AW = 20;
    localparam int SRAM_DW = 16;

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    typedef struct packed {
        logic               valid;
        logic               oor;
        logic               ub_n;
        logic               lb_n;
        logic [SRAM_AW-1:0] addr;
    } rd_req_t;

    localparam logic [SRAM_DW-1:0] RD_OOR_DATA  = 16'hFFFF;
    localparam logic [7:0]         RD_MASK_BYTE = 8'h00;

    // Byte enables are active-low; a disabled lane reads back as RD_MASK_BYTE.
    function automatic logic [SRAM_DW-1:0] mask_lanes(input logic [SRAM_DW-1:0] word,
                                                      input logic ub_n,
                                                      input logic lb_n);
        return {ub_n ? RD_MASK_BYTE : word[15:8], lb_n ? RD_MASK_BYTE : word[7:0]};
    endfunction

endpackage

// File: rtl/sram_if.sv
// Asynchronous-SRAM style bus (active-low strobes) with split data directions.
interface sram_if;
    import sram_pkg::*;

    logic               CE;
    logic               UB;
    logic               LB;
    logic               OE;
    logic               WE;
    logic [SRAM_AW-1:0] ADDR;
    logic [SRAM_DW-1:0] Data_in;
    logic [SRAM_DW-1:0] Data_out;
    logic               Data_oe;

    modport master (
        output CE, UB, LB, OE, WE, ADDR, Data_in,
        input  Data_out, Data_oe
    );

    modport slave (
        input  CE, UB, LB, OE, WE, ADDR, Data_in,
        output Data_out, Data_oe
    );

endinterface

// File: rtl/sram_rd_pipe.sv
// Fixed-depth shift register carrying sampled read requests; reset flushes every slot.
module sram_rd_pipe
    import sram_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk_i,
    input  logic    rst_n_i,
    input  rd_req_t req_i,
    output rd_req_t req_o
);

    rd_req_t stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= req_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign req_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sram_responder.sv
// On-chip stand-in for the 1Mx16 async SRAM: synchronous bus sampling, read latency,
// byte-lane masking, out-of-range detection and an optional power-up clear.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int READ_LAT   = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    sram_if.slave        bus,
    output logic         Busy,
    output logic         Range_err,
    output logic [15:0]  Rd_cnt,
    output logic [15:0]  Wr_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LAT   = (READ_LAT < 1) ? 1 : ((READ_LAT > 4) ? 4 : READ_LAT);

    logic [SRAM_DW-1:0] mem [DEPTH];

    state_t             state_q;
    logic [ADDR_W-1:0]  clr_ptr_q;
    logic               busy_q;
    logic               range_err_q;
    logic               wr_prev_q;
    logic               rd_prev_q;
    logic               data_oe_q;
    logic [SRAM_DW-1:0] data_out_q;
    logic [15:0]        rd_cnt_q;
    logic [15:0]        wr_cnt_q;

    logic               idle;
    logic               req_oor;
    logic               wr;
    logic               rd;
    logic [ADDR_W-1:0]  wr_idx;
    logic [ADDR_W-1:0]  rd_idx;
    logic               rd_oor;
    logic [SRAM_DW-1:0] rd_word;
    logic [SRAM_DW-1:0] rd_data_d;
    rd_req_t            req_in;
    rd_req_t            req_out;

    // Holding Reset low also blocks array writes when there is no clear phase.
    assign idle    = Reset && (state_q == IDLE);
    assign req_oor = (bus.ADDR >> ADDR_W) != '0;
    assign wr      = idle && !bus.CE && !bus.WE;
    assign rd      = idle && !bus.CE && bus.WE && !bus.OE;
    assign wr_idx  = bus.ADDR[ADDR_W-1:0];

    assign req_in = '{valid: rd, oor: req_oor, ub_n: bus.UB, lb_n: bus.LB, addr: bus.ADDR};

    sram_rd_pipe #(
        .DEPTH (LAT)
    ) u_rd_pipe (
        .clk_i   (Clk),
        .rst_n_i (Reset),
        .req_i   (req_in),
        .req_o   (req_out)
    );

    // The array is read when the request leaves the pipe, so earlier writes are visible.
    assign rd_idx    = req_out.addr[ADDR_W-1:0];
    assign rd_word   = mem[rd_idx];
    assign rd_oor    = req_out.oor || ((req_out.addr >> ADDR_W) != '0);
    assign rd_data_d = rd_oor ? RD_OOR_DATA : mask_lanes(rd_word, req_out.ub_n, req_out.lb_n);

    always_ff @(posedge Clk) begin
        if (state_q == INIT) begin
            mem[clr_ptr_q] <= '0;
        end else if (wr && !req_oor) begin
            if (!bus.UB) mem[wr_idx][15:8] <= bus.Data_in[15:8];
            if (!bus.LB) mem[wr_idx][7:0]  <= bus.Data_in[7:0];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= (INIT_CLEAR != 0) ? INIT : IDLE;
            clr_ptr_q   <= '0;
            busy_q      <= (INIT_CLEAR != 0);
            range_err_q <= 1'b0;
            wr_prev_q   <= 1'b0;
            rd_prev_q   <= 1'b0;
            data_oe_q   <= 1'b0;
            data_out_q  <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
                    if (&clr_ptr_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                IDLE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            // Counters count strobe entries, not cycles of an asserted strobe.
            wr_prev_q <= wr;
            rd_prev_q <= rd;
            if (wr && !wr_prev_q) wr_cnt_q <= wr_cnt_q + 16'd1;
            if (rd && !rd_prev_q) rd_cnt_q <= rd_cnt_q + 16'd1;

            if ((wr || rd) && req_oor) range_err_q <= 1'b1;

            data_oe_q <= req_out.valid;
            if (req_out.valid) data_out_q <= rd_data_d;
        end
    end

    assign bus.Data_out = data_out_q;
    assign bus.Data_oe  = data_oe_q;
    assign Busy         = busy_q;
    assign Range_err    = range_err_q;
    assign Rd_cnt       = rd_cnt_q;
    assign Wr_cnt       = wr_cnt_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench: default-parameter responder plus a wide, two-cycle-latency, no-clear one.
module tb_sram_responder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        busy_a, rerr_a, busy_b, rerr_b;
    logic [15:0] rdc_a, wrc_a, rdc_b, wrc_b;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 Clk = ~Clk;

    sram_if ifa ();
    sram_if ifb ();

    sram_responder dut_a (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (ifa),
        .Busy      (busy_a),
        .Range_err (rerr_a),
        .Rd_cnt    (rdc_a),
        .Wr_cnt    (wrc_a)
    );

    sram_responder #(
        .ADDR_W     (16),
        .READ_LAT   (2),
        .INIT_CLEAR (0)
    ) dut_b (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (ifb),
        .Busy      (busy_b),
        .Range_err (rerr_b),
        .Rd_cnt    (rdc_b),
        .Wr_cnt    (wrc_b)
    );

    task automatic idle_a();
        ifa.CE = 1'b1; ifa.WE = 1'b1; ifa.OE = 1'b1; ifa.UB = 1'b1; ifa.LB = 1'b1;
        ifa.ADDR = 20'h0; ifa.Data_in = 16'h0;
    endtask

    task automatic idle_b();
        ifb.CE = 1'b1; ifb.WE = 1'b1; ifb.OE = 1'b1; ifb.UB = 1'b1; ifb.LB = 1'b1;
        ifb.ADDR = 20'h0; ifb.Data_in = 16'h0;
    endtask

    task automatic wr_a(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
        ifa.CE = 1'b0; ifa.WE = 1'b0; ifa.OE = 1'b1; ifa.UB = ub; ifa.LB = lb;
        ifa.ADDR = a; ifa.Data_in = d;
    endtask

    task automatic rd_a(input logic [19:0] a, input logic ub, input logic lb);
        ifa.CE = 1'b0; ifa.WE = 1'b1; ifa.OE = 1'b0; ifa.UB = ub; ifa.LB = lb;
        ifa.ADDR = a; ifa.Data_in = 16'h0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        idle_a();
        idle_b();
        repeat (2) @(negedge Clk);
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL reset_busy_a: got %b expected 1", busy_a); end
        n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b: got %b expected 0", busy_b); end
        n_checks++; if (ifa.Data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", ifa.Data_oe); end
        n_checks++; if (ifa.Data_out !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", ifa.Data_out); end
        n_checks++; if (rerr_a !== 1'b0) begin n_fail++; $display("FAIL reset_rerr: got %b expected 0", rerr_a); end
        n_checks++; if (rdc_a !== 16'd0 || wrc_a !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got rd=%0d wr=%0d expected 0/0", rdc_a, wrc_a); end
    endtask

    task automatic test_init_clear();
        int cyc;
        Reset = 1'b1;
        cyc = 0;
        while (busy_a === 1'b1 && cyc < 2000) begin
            cyc++;
            @(negedge Clk);
        end
        n_checks++; if (cyc !== 1024) begin n_fail++; $display("FAIL init_busy_len: got %0d cycles expected 1024", cyc); end
        rd_a(20'h003FF, 1'b0, 1'b0);
        @(negedge Clk);
        idle_a();
        n_checks++; if (ifa.Data_oe !== 1'b0) begin n_fail++; $display("FAIL init_rd_early_oe: got %b expected 0", ifa.Data_oe); end
        @(negedge Clk);
        n_checks++; if (ifa.Data_oe !== 1'b1) begin n_fail++; $display("FAIL init_rd_oe: got %b expected 1", ifa.Data_oe); end
        n_checks++; if (ifa.Data_out !== 16'h0000) begin n_fail++; $display("FAIL init_rd_data: got %h expected 0000", ifa.Data_out); end
        @(negedge Clk);
        n_checks++; if (ifa.Data_oe !== 1'b0) begin n_fail++; $display("FAIL init_rd_oe_drop: got %b expected 0", ifa.Data_oe); end
    endtask

    task automatic test_lanes();
        wr_a(20'h00010, 16'h1234, 1'b0, 1'b0);
        @(negedge Clk); idle_a();
        @(negedge Clk); wr_a(20'h00010, 16'hAB00, 1'b0, 1'b1);
        @(negedge Clk); idle_a();
        @(negedge Clk); rd_a(20'h00010, 1'b1, 1'b0);
        @(negedge Clk); rd_a(20'h00010, 1'b0, 1'b0);
        n_checks++; if (ifa.Data_oe !== 1'b0) begin n_fail++; $display("FAIL lanes_early_oe: got %b expected 0", ifa.Data_oe); end
        @(negedge Clk); idle_a();
        n_checks++; if (ifa.Data_oe !== 1'b1 || ifa.Data_out !== 16'h0034) begin n_fail++; $display("FAIL lanes_ub_masked: got oe=%b %h expected oe=1 0034", ifa.Data_oe, ifa.Data_out); end
        @(negedge Clk);
        n_checks++; if (ifa.Data_oe !== 1'b1 || ifa.Data_out !== 16'hAB34) begin n_fail++; $display("FAIL lanes_full: got oe=%b %h expected oe=1 AB34", ifa.Data_oe, ifa.Data_out); end
        @(negedge Clk);
        n_checks++; if (ifa.Data_oe !== 1'b0 || ifa.Data_out !== 16'hAB34) begin n_fail++; $display("FAIL lanes_hold: got oe=%b %h expected oe=0 AB34", ifa.Data_oe, ifa.Data_out); end
        n_checks++; if (wrc_a !== 16'd2 || rdc_a !== 16'd2) begin n_fail++; $display("FAIL lanes_cnt: got wr=%0d rd=%0d expected 2/2", wrc_a, rdc_a); end
    endtask

    task automatic test_raw();
        wr_a(20'h00020, 16'h5A5A, 1'b0, 1'b0);
        @(negedge Clk); rd_a(20'h00020, 1'b0, 1'b0);
        @(negedge Clk); idle_a();
        n_checks++; if (ifa.Data_oe !== 1'b0) begin n_fail++; $display("FAIL raw_early_oe: got %b expected 0", ifa.Data_oe); end
        @(negedge Clk);
        n_checks++; if (ifa.Data_oe !== 1'b1 || ifa.Data_out !== 16'h5A5A) begin n_fail++; $display("FAIL raw_data: got oe=%b %h expected oe=1 5A5A", ifa.Data_oe, ifa.Data_out); end
        n_checks++; if (wrc_a !== 16'd3 || rdc_a !== 16'd3) begin n_fail++; $display("FAIL raw_wr_to_rd_cnt: got wr=%0d rd=%0d expected 3/3", wrc_a, rdc_a); end
        rd_a(20'h00020, 1'b0, 1'b0);
        @(negedge Clk); wr_a(20'h00020, 16'h5A5A, 1'b0, 1'b0);
        @(negedge Clk); idle_a();
        @(negedge Clk);
        n_checks++; if (wrc_a !== 16'd4 || rdc_a !== 16'd4) begin n_fail++; $display("FAIL raw_rd_to_wr_cnt: got wr=%0d rd=%0d expected 4/4", wrc_a, rdc_a); end
    endtask

    task automatic test_held_write();
        wr_a(20'h00030, 16'h1111, 1'b0, 1'b0);
        @(negedge Clk); wr_a(20'h00030, 16'h2222, 1'b0, 1'b0);
        @(negedge Clk); idle_a();
        @(negedge Clk); rd_a(20'h00030, 1'b0, 1'b0);
        @(negedge Clk); idle_a();
        @(negedge Clk);
        n_checks++; if (ifa.Data_out !== 16'h2222) begin n_fail++; $display("FAIL held_last_wins: got %h expected 2222", ifa.Data_out); end
        n_checks++; if (wrc_a !== 16'd5 || rdc_a !== 16'd5) begin n_fail++; $display("FAIL held_cnt: got wr=%0d rd=%0d expected 5/5", wrc_a, rdc_a); end
    endtask

    task automatic test_out_of_range();
        n_checks++; if (rerr_a !== 1'b0) begin n_fail++; $display("FAIL oor_pre_rerr: got %b expected 0", rerr_a); end
        wr_a(20'h00400, 16'h1111, 1'b0, 1'b0);
        @(negedge Clk); idle_a();
        n_checks++; if (rerr_a !== 1'b1) begin n_fail++; $display("FAIL oor_wr_rerr: got %b expected 1", rerr_a); end
        @(negedge Clk); rd_a(20'h00400, 1'b0, 1'b0);
        @(negedge Clk); idle_a();
        @(negedge Clk);
        n_checks++; if (ifa.Data_oe !== 1'b1 || ifa.Data_out !== 16'hFFFF) begin n_fail++; $display("FAIL oor_rd_data: got oe=%b %h expected oe=1 FFFF", ifa.Data_oe, ifa.Data_out); end
        rd_a(20'h00000, 1'b0, 1'b0);
        @(negedge Clk); idle_a();
        @(negedge Clk);
        n_checks++; if (ifa.Data_oe !== 1'b1 || ifa.Data_out !== 16'h0000) begin n_fail++; $display("FAIL oor_no_alias: got oe=%b %h expected oe=1 0000", ifa.Data_oe, ifa.Data_out); end
        n_checks++; if (rerr_a !== 1'b1) begin n_fail++; $display("FAIL oor_sticky: got %b expected 1", rerr_a); end
        n_checks++; if (wrc_a !== 16'd6 || rdc_a !== 16'd7) begin n_fail++; $display("FAIL oor_cnt: got wr=%0d rd=%0d expected 6/7", wrc_a, rdc_a); end
    endtask

    task automatic test_wide_lat2();
        ifb.CE = 1'b0; ifb.WE = 1'b0; ifb.OE = 1'b1; ifb.UB = 1'b0; ifb.LB = 1'b0;
        ifb.ADDR = 20'h03000; ifb.Data_in = 16'hBEEF;
        @(negedge Clk);
        ifb.WE = 1'b1; ifb.OE = 1'b0; ifb.Data_in = 16'h0;
        @(negedge Clk); idle_b();
        n_checks++; if (ifb.Data_oe !== 1'b0) begin n_fail++; $display("FAIL lat2_oe_edge1: got %b expected 0", ifb.Data_oe); end
        @(negedge Clk);
        n_checks++; if (ifb.Data_oe !== 1'b0) begin n_fail++; $display("FAIL lat2_oe_edge2: got %b expected 0", ifb.Data_oe); end
        @(negedge Clk);
        n_checks++; if (ifb.Data_oe !== 1'b1 || ifb.Data_out !== 16'hBEEF) begin n_fail++; $display("FAIL lat2_data: got oe=%b %h expected oe=1 BEEF", ifb.Data_oe, ifb.Data_out); end
        n_checks++; if (wrc_b !== 16'd1 || rdc_b !== 16'd1) begin n_fail++; $display("FAIL lat2_cnt: got wr=%0d rd=%0d expected 1/1", wrc_b, rdc_b); end
        n_checks++; if (rerr_b !== 1'b0) begin n_fail++; $display("FAIL lat2_rerr: got %b expected 0", rerr_b); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        rd_a(20'h00020, 1'b0, 1'b0);
        @(negedge Clk); idle_a();
        @(negedge Clk);
        n_checks++; if (ifa.Data_oe !== 1'b1) begin n_fail++; $display("FAIL mid_pre_oe: got %b expected 1", ifa.Data_oe); end
        Reset = 1'b0;
        #1;
        n_checks++; if (ifa.Data_oe !== 1'b0) begin n_fail++; $display("FAIL mid_rd_oe_async: got %b expected 0", ifa.Data_oe); end
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL mid_rd_busy: got %b expected 1", busy_a); end
        n_checks++; if (rdc_a !== 16'd0 || wrc_a !== 16'd0 || rerr_a !== 1'b0) begin n_fail++; $display("FAIL mid_rd_clear: got rd=%0d wr=%0d rerr=%b expected 0/0/0", rdc_a, wrc_a, rerr_a); end
        @(negedge Clk); Reset = 1'b1;
        repeat (500) @(negedge Clk);
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL mid_init_busy: got %b expected 1", busy_a); end
        Reset = 1'b0;
        @(negedge Clk); Reset = 1'b1;
        cyc = 0;
        while (busy_a === 1'b1 && cyc < 2000) begin
            cyc++;
            @(negedge Clk);
        end
        n_checks++; if (cyc !== 1024) begin n_fail++; $display("FAIL mid_init_restart_len: got %0d cycles expected 1024", cyc); end
        rd_a(20'h00010, 1'b0, 1'b0);
        @(negedge Clk); idle_a();
        @(negedge Clk);
        n_checks++; if (ifa.Data_out !== 16'h0000) begin n_fail++; $display("FAIL mid_recleared: got %h expected 0000", ifa.Data_out); end
        n_checks++; if (rdc_a !== 16'd1 || wrc_a !== 16'd0) begin n_fail++; $display("FAIL mid_cnt_restart: got rd=%0d wr=%0d expected 1/0", rdc_a, wrc_a); end
    endtask

    initial begin
        test_reset();
        test_init_clear();
        test_lanes();
        test_raw();
        test_held_write();
        test_out_of_range();
        test_wide_lat2();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
